// File: rtl/vga_pkg.sv
// Shared constants and pipeline types for the VGA frame reader.
// Default 640x480@60 timing, default image geometry, stage-0 flag bundle.
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int DEF_IMG_W = 256;
  localparam int DEF_IMG_H = 256;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FP
                         + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FP
                         + DEF_V_SYNC + DEF_V_BP;

  // Counter width for h/v positions.
  localparam int CW = 16;

  // hs/vs hold the pin level (active-low), not an "asserted" bit.
  typedef struct packed {
    logic in_img;
    logic visible;
    logic hs;
    logic vs;
    logic first;
  } pix_flags_t;

  localparam pix_flags_t FLAGS_IDLE = '{
    in_img:  1'b0,
    visible: 1'b0,
    hs:      1'b1,
    vs:      1'b1,
    first:   1'b0
  };

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider, h/v raster counters and stage-0 flag decode.
// Ports: i_clk, i_reset (sync, active-low), o_tick, o_h, o_v, o_flags.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H
) (
  input  logic          i_clk,
  input  logic          i_reset,
  output logic          o_tick,
  output logic [CW-1:0] o_h,
  output logic [CW-1:0] o_v,
  output pix_flags_t    o_flags
);

  localparam logic [CW-1:0] H_LAST =
    CW'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_LAST =
    CW'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  localparam logic [CW-1:0] H_VIS = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS = CW'(V_VISIBLE);
  localparam logic [CW-1:0] IW    = CW'(IMG_W);
  localparam logic [CW-1:0] IH    = CW'(IMG_H);

  localparam logic [CW-1:0] HS_BEG = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_VISIBLE + V_FP + V_SYNC);

  logic          r_tick;
  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;

  // r_tick rises on the first clk after release, so the first
  // active pixel edge is the second clk after release.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_tick <= 1'b0;
      r_h    <= '0;
      r_v    <= '0;
    end else begin
      r_tick <= ~r_tick;
      if (r_tick) begin
        if (r_h == H_LAST) begin
          r_h <= '0;
          if (r_v == V_LAST) r_v <= '0;
          else               r_v <= r_v + CW'(1);
        end else begin
          r_h <= r_h + CW'(1);
        end
      end
    end
  end

  always_comb begin
    o_flags         = FLAGS_IDLE;
    o_flags.in_img  = (r_h < IW) && (r_v < IH);
    o_flags.visible = (r_h < H_VIS) && (r_v < V_VIS);
    o_flags.hs      = !((r_h >= HS_BEG) && (r_h < HS_END));
    o_flags.vs      = !((r_v >= VS_BEG) && (r_v < VS_END));
    o_flags.first   = (r_h == '0) && (r_v == '0);
  end

  assign o_tick = r_tick;
  assign o_h    = r_h;
  assign o_v    = r_v;

endmodule

// File: rtl/vga_frame_reader.sv
// Display-side frame reader: raster timing, pixel fetch, grayscale out.
// Ports: i_clk, i_reset, o_vga_addr/i_vga_data, o_hsync, o_vsync,
// o_blank_n, o_red/o_green/o_blue, o_frame_start.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int          H_VISIBLE = DEF_H_VISIBLE,
  parameter int          H_FP      = DEF_H_FP,
  parameter int          H_SYNC    = DEF_H_SYNC,
  parameter int          H_BP      = DEF_H_BP,
  parameter int          V_VISIBLE = DEF_V_VISIBLE,
  parameter int          V_FP      = DEF_V_FP,
  parameter int          V_SYNC    = DEF_V_SYNC,
  parameter int          V_BP      = DEF_V_BP,
  parameter int          IMG_W     = DEF_IMG_W,
  parameter int          IMG_H     = DEF_IMG_H,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [31:0] o_vga_addr,
  input  logic [7:0]  i_vga_data,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_blank_n,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_frame_start
);

  logic          w_tick;
  logic [CW-1:0] w_h;
  logic [CW-1:0] w_v;
  pix_flags_t    w_flags;
  logic [31:0]   w_pix_addr;

  pix_flags_t    r_flags;
  logic [31:0]   r_addr;
  logic [7:0]    r_pix;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_blank_n;
  logic          r_frame_start;

  vga_timing_gen #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H)
  ) u_timing (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (w_tick),
    .o_h     (w_h),
    .o_v     (w_v),
    .o_flags (w_flags)
  );

  assign w_pix_addr = BASE_ADDR
                    + 32'(w_v) * 32'(IMG_W)
                    + 32'(w_h);

  // Stage 0 issues the read; stage 1 consumes the data one tick
  // later, so sync/blank travel with the pixel they describe.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_flags       <= FLAGS_IDLE;
      r_addr        <= BASE_ADDR;
      r_pix         <= 8'h00;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_tick) begin
      r_flags   <= w_flags;
      r_addr    <= w_flags.in_img ? w_pix_addr : BASE_ADDR;
      r_pix     <= (r_flags.in_img && r_flags.visible)
                   ? i_vga_data : 8'h00;
      r_hsync   <= r_flags.hs;
      r_vsync   <= r_flags.vs;
      r_blank_n <= r_flags.visible;
      r_frame_start <= r_flags.first;
    end else begin
      r_frame_start <= 1'b0;
    end
  end

  assign o_vga_addr    = r_addr;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_blank_n     = r_blank_n;
  assign o_red         = r_pix;
  assign o_green       = r_pix;
  assign o_blue        = r_pix;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader: full-size timing instance
// plus a shrunken-raster instance with a tiny image at 0x1000.
module tb_vga_frame_reader;

  typedef struct {
    int hv, hf, hs, hb;
    int vv, vf, vs, vb;
    int iw, ih;
    logic [31:0] base;
  } cfg_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  rgb;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        first;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic [31:0] addr  [2];
  logic [7:0]  vd    [2];
  logic        hs    [2];
  logic        vs    [2];
  logic        bl    [2];
  logic        fs    [2];
  logic [7:0]  rr    [2];
  logic [7:0]  gg    [2];
  logic [7:0]  bb    [2];

  logic [7:0] mem [65536];

  int   ec [2];
  exp_t q  [2][$];
  exp_t last [2];

  int n_chk  = 0;
  int n_pass = 0;

  vga_frame_reader u_a (
    .i_clk         (clk),
    .i_reset       (rst_n[0]),
    .o_vga_addr    (addr[0]),
    .i_vga_data    (vd[0]),
    .o_hsync       (hs[0]),
    .o_vsync       (vs[0]),
    .o_blank_n     (bl[0]),
    .o_red         (rr[0]),
    .o_green       (gg[0]),
    .o_blue        (bb[0]),
    .o_frame_start (fs[0])
  );

  vga_frame_reader #(
    .H_VISIBLE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_VISIBLE (8),  .V_FP (1), .V_SYNC (2), .V_BP (2),
    .IMG_W (4), .IMG_H (4), .BASE_ADDR (32'h1000)
  ) u_b (
    .i_clk         (clk),
    .i_reset       (rst_n[1]),
    .o_vga_addr    (addr[1]),
    .i_vga_data    (vd[1]),
    .o_hsync       (hs[1]),
    .o_vsync       (vs[1]),
    .o_blank_n     (bl[1]),
    .o_red         (rr[1]),
    .o_green       (gg[1]),
    .o_blue        (bb[1]),
    .o_frame_start (fs[1])
  );

  function automatic cfg_t cfg(input int i);
    cfg_t c;
    if (i == 0)
      c = '{640, 16, 96, 48, 480, 10, 2, 33,
            256, 256, 32'h0};
    else
      c = '{16, 2, 4, 3, 8, 1, 2, 2,
            4, 4, 32'h1000};
    return c;
  endfunction

  // Expected pins for the k-th pixel after reset release.
  function automatic exp_t expect_pix(input int i, input int k);
    cfg_t c;
    exp_t e;
    int ht, vt, h, v;
    bit img, vis;
    c   = cfg(i);
    ht  = c.hv + c.hf + c.hs + c.hb;
    vt  = c.vv + c.vf + c.vs + c.vb;
    h   = k % ht;
    v   = (k / ht) % vt;
    img = (h < c.iw) && (v < c.ih);
    vis = (h < c.hv) && (v < c.vv);
    e.addr  = img ? c.base + 32'(v * c.iw + h) : c.base;
    e.rgb   = (img && vis) ? mem[e.addr[15:0]] : 8'h00;
    e.blank = vis;
    e.hs    = !(h >= c.hv + c.hf && h < c.hv + c.hf + c.hs);
    e.vs    = !(v >= c.vv + c.vf && v < c.vv + c.vf + c.vs);
    e.first = (h == 0) && (v == 0);
    return e;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s[%0d] e=%0d got %h want %h",
                  nm, i, ec[i], act, req);
  endtask

  // Memory model + stimulus side: edge counter, expected pushes.
  // Data is garbled right after each sampling edge to show it
  // only matters on ticks.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        ec[i] = 0;
        q[i].delete();
        vd[i] <= 8'($urandom);
      end else begin
        ec[i] = ec[i] + 1;
        if (ec[i] % 2 == 1) begin
          vd[i] <= mem[addr[i][15:0]];
        end else begin
          vd[i] <= 8'($urandom);
          q[i].push_back(expect_pix(i, (ec[i] - 2) / 2));
        end
      end
    end
  end

  // Monitor: compare on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cfg_t c;
      int e;
      logic [31:0] pins;
      c    = cfg(i);
      e    = ec[i];
      pins = {4'h0, rr[i], gg[i], bb[i],
              hs[i], vs[i], bl[i], fs[i]};
      if (e < 2) begin
        chk("addr_rst", i, addr[i], c.base);
      end else if (e % 2 == 0) begin
        if (q[i].size() == 0)
          chk("addr_q", i, 32'd0, 32'd1);
        else
          chk("addr", i, addr[i],
              q[i][q[i].size() - 1].addr);
      end
      if (e < 4) begin
        chk("pins_rst", i, pins, 32'h0000_000C);
      end else if (e % 2 == 0) begin
        if (q[i].size() == 0) begin
          chk("pins_q", i, 32'd0, 32'd1);
        end else begin
          last[i] = q[i].pop_front();
          chk("pins", i, pins,
              {4'h0, last[i].rgb, last[i].rgb, last[i].rgb,
               last[i].hs, last[i].vs, last[i].blank,
               last[i].first});
        end
      end else begin
        chk("pins_hold", i, pins,
            {4'h0, last[i].rgb, last[i].rgb, last[i].rgb,
             last[i].hs, last[i].vs, last[i].blank, 1'b0});
      end
    end
  end

  // Aggregate timing measurements.
  int   hs_fall [$];
  int   hs_low  = 0;
  logic hs_prev = 1'b1;
  int   fs_e    [$];
  int   bl_cnt  = 0;
  int   vs_cnt  = 0;

  always @(negedge clk) begin
    if (ec[0] > 0) begin
      if (hs_prev && !hs[0]) hs_fall.push_back(ec[0]);
      if (!hs[0] && hs_fall.size() == 1) hs_low++;
      hs_prev = hs[0];
    end
    if (ec[1] > 0 && fs[1] && fs_e.size() < 3)
      fs_e.push_back(ec[1]);
    if (fs_e.size() == 2) begin
      if (bl[1])  bl_cnt++;
      if (!vs[1]) vs_cnt++;
    end
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    repeat (5) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2000 + $urandom_range(0, 649)) @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (2500) @(negedge clk);

    chk("hs_fall0", 0,
        hs_fall.size() > 0 ? hs_fall[0] : -1, 1316);
    chk("line_period", 0,
        hs_fall.size() > 1 ? hs_fall[1] - hs_fall[0] : -1,
        1600);
    chk("hs_low_clks", 0, hs_low, 192);
    chk("fs_first", 1, fs_e.size() > 0 ? fs_e[0] : -1, 4);
    chk("frame_period", 1,
        fs_e.size() > 1 ? fs_e[1] - fs_e[0] : -1, 650);
    chk("frame_period2", 1,
        fs_e.size() > 2 ? fs_e[2] - fs_e[1] : -1, 650);
    chk("blank_clks", 1, bl_cnt, 256);
    chk("vs_low_clks", 1, vs_cnt, 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Display-side reader for the data memory that the vector CPU writes.
- Generates 640x480@60 VGA timing from a divided pixel tick.
- Fetches 8-bit pixels from the memory's VGA read port (address out, data in, 1-clk synchronous read).
- Drives grayscale RGB, with sync and blanking aligned to the fetched data.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- IMG_W, 256, image width in pixels, stored row-major in memory
- IMG_H, 256, image height in lines
- BASE_ADDR, 0, memory address of pixel (0,0)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- vga_addr  out  32  read address to the memory VGA port
- vga_data  in  8  read data, valid 1 clk after vga_addr
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- blank_n  out  1  high during the visible region
- red  out  8  pixel intensity
- green  out  8  pixel intensity
- blue  out  8  pixel intensity
- frame_start  out  1  1-clk pulse at the first visible pixel of each frame

Behaviour:
- Reset (reset==0 at posedge clk): tick=0, h_cnt=0, v_cnt=0, hsync=1, vsync=1, blank_n=0, red/green/blue=0, vga_addr=BASE_ADDR, frame_start=0. Applies mid-frame: the next frame restarts at (0,0).
- Pixel tick: 1-bit toggle every clk after reset release. A tick is asserted on every 2nd clk, on the first clk after release and then every other clk.
- Counters advance only on tick:
  - h_cnt 0..H_TOTAL-1, with H_TOTAL = sum of the four H_* parameters = 800.
  - At wrap, h_cnt returns to 0 and v_cnt increments, 0..V_TOTAL-1 (525), then wraps to 0.
- Stage 0 (tick at counters h,v):
  - When h<IMG_W and v<IMG_H, register vga_addr = BASE_ADDR + v*IMG_W + h (32-bit unsigned add, no saturation).
  - Otherwise vga_addr = BASE_ADDR.
  - Also register the stage-0 flags: in_img, visible (h<H_VISIBLE && v<V_VISIBLE), hs, vs, first (h==0 && v==0).
  - hs asserted (0) for H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC; vs likewise on v.
- Stage 1 (next tick, 2 clks later; memory data has been valid since clk+1):
  - red=green=blue = vga_data when the in_img and visible flags are set, else 0.
  - blank_n = visible flag; hsync = hs flag; vsync = vs flag.
  - frame_start = first flag, held high for exactly 1 clk (the clk of the tick) and 0 otherwise.
- Total latency from counter state to pins: 1 pixel (2 clks). Sync and RGB always come from the same stage, so they stay aligned.
- Image larger than screen (IMG_W>H_VISIBLE): only visible pixels are shown; no error.
- vga_data is sampled only on ticks; changes between ticks have no effect.
- Outputs are all registered; there is no combinational path from vga_data to the pins.

Decomposition:
- Package vga_pkg holds:
  - the timing constants as defaults;
  - H_TOTAL/V_TOTAL localparams;
  - a typedef struct {in_img, visible, hs, vs, first} pix_flags_t for the pipeline stage.
- Sub-module vga_timing_gen contains the tick divider, h/v counters and the stage-0 flag decode.
- vga_frame_reader wraps vga_timing_gen and adds the address generation and stage-1 output registers.

Test Plan:
- Reset held 5 clks, then released:
  - all outputs equal their reset values during reset;
  - first vga_addr=0x0;
  - frame_start pulses at clk 4 after release.
- Line timing: run 1 line, count ticks.
  - hsync low for exactly 96 ticks, starting at pixel 657 on the pins (1-pixel latency).
  - Line period = 1600 clks.
- Frame timing, full frame:
  - vsync low for 2 lines starting at line 490.
  - frame_start pulses exactly once per 840000 clks.
  - blank_n is high for 640x480 ticks.
- Memory model returns addr[7:0]:
  - at (h=5,v=2), vga_addr=517;
  - one pixel later red=green=blue=0x05;
  - at h=300, RGB=0 while blank_n=1.
- Reset asserted mid-frame at (h=400,v=200) for 1 clk:
  - counters return to (0,0);
  - vsync/hsync go to 1 and blank_n to 0 on that edge.
- BASE_ADDR=0x1000, IMG_W=IMG_H=4:
  - pixel (3,3) → vga_addr=0x100F;
  - pixel (4,0) → vga_addr=0x1000, RGB=0.
